sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_pkg.sv | 24 ++
 rtl/sram_wait_cnt.sv | 29 ++
 rtl/sram_ctrl.sv | 119 +++++++++++
 tb/tb_sram_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared types and constants for the 32-bit over 16-bit SRAM controller
// Macro SRAM_BASE_OFFSET_EN selects whether the SRAM window starts at byte address SRAM_BASE.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_DONE
  } state_t;

  localparam logic [31:0] SRAM_BASE   = 32'd1024;
  localparam int          SRAM_ADDR_W = 18;
  localparam int          SRAM_DATA_W = 16;

  function automatic logic [31:0] effective_addr(input logic [31:0] addr);
`ifdef SRAM_BASE_OFFSET_EN
    return addr - SRAM_BASE;
`else
    return addr;
`endif
  endfunction

endpackage

// File: rtl/sram_wait_cnt.sv
// rtl/sram_wait_cnt.sv - per-half wait counter, done after WAIT_CYCLES+1 counted cycles
// Cleared on every state entry so each half access gets the full wait budget.
module sram_wait_cnt #(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic done
);

  localparam logic [2:0] LAST = 3'(WAIT_CYCLES);

  logic [2:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 3'd0;
    end else if (clr) begin
      cnt <= 3'd0;
    end else if (en && !done) begin
      cnt <= cnt + 3'd1;
    end
  end

  assign done = (cnt == LAST);

endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - MEM-stage controller splitting 32-bit accesses into two 16-bit SRAM halves
// Macro SRAM_BASE_OFFSET_EN: when defined, byte address SRAM_BASE maps to SRAM half-word 0.
module sram_ctrl
  import sram_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            address,
  input  logic [31:0]            write_data,
  output logic [31:0]            read_data,
  output logic                   ready,
  inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);

  state_t state, state_next;

  logic                   op_wr;
  logic [16:0]            word_q;
  logic [31:0]            wdata_q;
  logic [SRAM_DATA_W-1:0] lo_q;
  logic                   cnt_done;
  logic                   cnt_clr;
  logic                   cnt_en;
  logic                   dq_oe;
  logic [SRAM_DATA_W-1:0] dq_out;
  logic [31:0]            ea;
  logic                   unused_ea_bits;

  assign ea             = effective_addr(address);
  assign unused_ea_bits = ^{ea[31:19], ea[1:0]};
  assign ready          = ~(rd_en | wr_en) | (state == ST_DONE);
  assign cnt_clr        = (state_next != state);
  assign cnt_en         = (state == ST_LO) || (state == ST_HI);

  sram_wait_cnt #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_wait_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .en  (cnt_en),
    .done(cnt_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Operation, address and store data are frozen at request acceptance; a write wins over a read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_wr     <= 1'b0;
      word_q    <= '0;
      wdata_q   <= '0;
      lo_q      <= '0;
      read_data <= '0;
    end else begin
      if (state == ST_IDLE && (rd_en || wr_en)) begin
        op_wr   <= wr_en;
        word_q  <= ea[18:2];
        wdata_q <= write_data;
      end
      if (state == ST_LO && cnt_done && !op_wr) begin
        lo_q <= SRAM_DQ;
      end
      if (state == ST_HI && cnt_done && !op_wr) begin
        read_data <= {SRAM_DQ, lo_q};
      end
    end
  end

  always_comb begin
    state_next = state;
    SRAM_UB_N  = 1'b1;
    SRAM_LB_N  = 1'b1;
    SRAM_WE_N  = 1'b1;
    SRAM_CE_N  = 1'b1;
    SRAM_OE_N  = 1'b1;
    SRAM_ADDR  = '0;
    dq_oe      = 1'b0;
    dq_out     = '0;

    case (state)
      ST_IDLE: if (rd_en || wr_en) state_next = ST_LO;
      ST_LO:   if (cnt_done) state_next = ST_HI;
      ST_HI:   if (cnt_done) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase

    if (state == ST_LO || state == ST_HI) begin
      SRAM_UB_N = 1'b0;
      SRAM_LB_N = 1'b0;
      SRAM_CE_N = 1'b0;
      SRAM_WE_N = ~op_wr;
      SRAM_OE_N = op_wr;
      SRAM_ADDR = {word_q, (state == ST_HI)};
      dq_oe     = op_wr;
      dq_out    = (state == ST_HI) ? wdata_q[31:16] : wdata_q[15:0];
    end
  end

  assign SRAM_DQ = dq_oe ? dq_out : {SRAM_DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// tb/tb_sram_ctrl.sv - directed bench for sram_ctrl with a half-word SRAM model
// Addresses are written relative to BASE so the bench fits either SRAM_BASE_OFFSET_EN build.
module tb_sram_ctrl;

`ifdef SRAM_BASE_OFFSET_EN
  localparam logic [31:0] BASE = 32'd1024;
`else
  localparam logic [31:0] BASE = 32'd0;
`endif

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  wire  [15:0] SRAM_DQ;
  logic [17:0] SRAM_ADDR;
  logic        SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;

  logic [15:0] mem [0:1023];
  int          tests = 0;
  int          fails = 0;
  int          we_low;
  int          oe_low;

  sram_ctrl #(.WAIT_CYCLES(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .address   (address),
    .write_data(write_data),
    .read_data (read_data),
    .ready     (ready),
    .SRAM_DQ   (SRAM_DQ),
    .SRAM_ADDR (SRAM_ADDR),
    .SRAM_UB_N (SRAM_UB_N),
    .SRAM_LB_N (SRAM_LB_N),
    .SRAM_WE_N (SRAM_WE_N),
    .SRAM_CE_N (SRAM_CE_N),
    .SRAM_OE_N (SRAM_OE_N)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? mem[SRAM_ADDR[9:0]] : 16'hzzzz;

  always @(posedge clk) begin
    if (!SRAM_CE_N && !SRAM_WE_N) mem[SRAM_ADDR[9:0]] <= SRAM_DQ;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  function automatic logic [31:0] strobes();
    return {27'd0, SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N};
  endfunction

  initial begin
    rst        = 1'b1;
    rd_en      = 1'b0;
    wr_en      = 1'b0;
    address    = '0;
    write_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] <= 16'h0000;
    mem[4] <= 16'h5678;
    mem[5] <= 16'h1234;

    @(negedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_strobes", strobes(), 32'h1f);
    check("reset_addr", {14'd0, SRAM_ADDR}, 32'd0);
    check("reset_read_data", read_data, 32'd0);
    rst = 1'b0;
    tick();

    // Read of SRAM half-words 4/5: ready low for cycles 0-4, high in cycle 5.
    address = BASE + 32'h8;
    rd_en   = 1'b1;
    #1;
    for (int c = 0; c <= 5; c++) begin
      check("rd_ready", {31'd0, ready}, (c == 5) ? 32'd1 : 32'd0);
      if (c == 1) begin
        check("rd_addr_lo", {14'd0, SRAM_ADDR}, 32'd4);
        check("rd_dq_lo", {16'd0, SRAM_DQ}, 32'h5678);
        check("rd_oe_lo", {31'd0, SRAM_OE_N}, 32'd0);
      end
      if (c == 2) check("rd_addr_lo2", {14'd0, SRAM_ADDR}, 32'd4);
      if (c == 3) check("rd_addr_hi", {14'd0, SRAM_ADDR}, 32'd5);
      if (c == 4) check("rd_addr_hi2", {14'd0, SRAM_ADDR}, 32'd5);
      if (c == 5) begin
        check("rd_data", read_data, 32'h12345678);
        check("rd_done_strobes", strobes(), 32'h1f);
      end
      if (c < 5) tick();
    end
    rd_en = 1'b0;
    tick();
    check("rd_idle_ready", {31'd0, ready}, 32'd1);

    // Write: WE_N low for exactly the four LO/HI cycles, OE_N never low.
    address    = BASE;
    write_data = 32'hCAFEBABE;
    wr_en      = 1'b1;
    we_low     = 0;
    oe_low     = 0;
    #1;
    for (int c = 0; c <= 5; c++) begin
      if (!SRAM_WE_N) we_low++;
      if (!SRAM_OE_N) oe_low++;
      if (c == 1) check("wr_dq_lo", {16'd0, SRAM_DQ}, 32'hBABE);
      if (c == 3) check("wr_dq_hi", {16'd0, SRAM_DQ}, 32'hCAFE);
      if (c == 5) check("wr_ready", {31'd0, ready}, 32'd1);
      if (c < 5) tick();
    end
    wr_en = 1'b0;
    tick();
    check("wr_we_low_cycles", we_low, 32'd4);
    check("wr_oe_low_cycles", oe_low, 32'd0);
    check("wr_mem0", {16'd0, mem[0]}, 32'hBABE);
    check("wr_mem1", {16'd0, mem[1]}, 32'hCAFE);

    // Read and write together: the write is performed, read_data keeps its last value.
    address    = BASE + 32'h4;
    write_data = 32'h11112222;
    rd_en      = 1'b1;
    wr_en      = 1'b1;
    #1;
    for (int c = 0; c <= 5; c++) begin
      if (c == 1) check("both_we_lo", {31'd0, SRAM_WE_N}, 32'd0);
      if (c == 5) begin
        check("both_ready", {31'd0, ready}, 32'd1);
        check("both_read_data", read_data, 32'h12345678);
      end
      if (c < 5) tick();
    end
    rd_en = 1'b0;
    wr_en = 1'b0;
    tick();
    check("both_mem2", {16'd0, mem[2]}, 32'h2222);
    check("both_mem3", {16'd0, mem[3]}, 32'h1111);
    check("both_read_data_after", read_data, 32'h12345678);

    // Reset during the HI half of a read aborts everything immediately.
    address = BASE + 32'h8;
    rd_en   = 1'b1;
    tick();
    tick();
    tick();
    check("abort_in_hi_addr", {14'd0, SRAM_ADDR}, 32'd5);
    rst   = 1'b1;
    rd_en = 1'b0;
    #1;
    check("abort_strobes", strobes(), 32'h1f);
    check("abort_read_data", read_data, 32'd0);
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_addr", {14'd0, SRAM_ADDR}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    check("abort_after_release_strobes", strobes(), 32'h1f);

    // Back-to-back reads with the request held: completions in cycles 5 and 11.
    address = BASE;
    rd_en   = 1'b1;
    #1;
    for (int c = 0; c <= 11; c++) begin
      check("b2b_ready", {31'd0, ready}, (c == 5 || c == 11) ? 32'd1 : 32'd0);
      if (c == 5) begin
        check("b2b_first_data", read_data, 32'hCAFEBABE);
        address = BASE + 32'h4;
      end
      if (c == 9) check("b2b_second_addr_hi", {14'd0, SRAM_ADDR}, 32'd3);
      if (c == 11) check("b2b_second_data", read_data, 32'h11112222);
      if (c < 11) tick();
    end
    rd_en = 1'b0;
    tick();
    check("b2b_idle_ready", {31'd0, ready}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
